// File: rtl/hub75_pkg.sv
// Shared encodings for the line-buffer ping-pong scheduler.
// The bank bit sits directly above the column bits in the buffer address.
package hub75_pkg;

  localparam int LOG_N_COLS_DFLT = 6;
  localparam int BANK_BIT        = LOG_N_COLS_DFLT;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DATA = 2'd2
  } fill_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/hub75_linebuf_sched_if.sv
// Fill, drain, output and line-buffer port bundle of the scheduler.
// master = scheduler side, slave = producer/consumer/buffer side.
interface hub75_linebuf_sched_if #(
  parameter int LOG_N_COLS = 6,
  parameter int LOG_N_ROWS = 5,
  parameter int DATA_WIDTH = 48
);
  logic                  fill_req;
  logic [LOG_N_ROWS-1:0] fill_row;
  logic                  fill_ack;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_valid;
  logic                  drain_rdy;
  logic [LOG_N_ROWS-1:0] drain_row;
  logic                  drain_start;
  logic                  drain_release;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic [LOG_N_COLS:0]   lb_wr_addr;
  logic [DATA_WIDTH-1:0] lb_wr_data;
  logic                  lb_wr_mask;
  logic                  lb_wr_ena;
  logic [LOG_N_COLS:0]   lb_rd_addr;
  logic                  lb_rd_ena;
  logic [DATA_WIDTH-1:0] lb_rd_data;

  modport master (
    output fill_req, fill_row, drain_rdy, drain_row, out_data, out_valid, out_last,
           lb_wr_addr, lb_wr_data, lb_wr_mask, lb_wr_ena, lb_rd_addr, lb_rd_ena,
    input  fill_ack, fill_data, fill_valid, drain_start, drain_release, lb_rd_data
  );

  modport slave (
    input  fill_req, fill_row, drain_rdy, drain_row, out_data, out_valid, out_last,
           lb_wr_addr, lb_wr_data, lb_wr_mask, lb_wr_ena, lb_rd_addr, lb_rd_ena,
    output fill_ack, fill_data, fill_valid, drain_start, drain_release, lb_rd_data
  );

endinterface

// File: rtl/hub75_linebuf_rdseq.sv
// Read sequencer: one full-line pass per accepted start, out_valid/out_last trail rd_ena by 1 cycle.
// Start is only honoured in R_IDLE; the caller qualifies it with bank availability.
module hub75_linebuf_rdseq
  import hub75_pkg::*;
#(
  parameter int LOG_N_COLS = LOG_N_COLS_DFLT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_rd_bank,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rd_ena,
  output logic [LOG_N_COLS:0] o_rd_addr,
  output logic                o_out_valid,
  output logic                o_out_last
);

  localparam logic [LOG_N_COLS-1:0] LAST_COL = '1;

  rd_state_t             r_state;
  logic [LOG_N_COLS-1:0] r_rcol;
  logic                  r_bank;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  w_last;

  assign w_last = (r_state == R_READ) && (r_rcol == LAST_COL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= R_IDLE;
      r_rcol      <= '0;
      r_bank      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= (r_state == R_READ);
      r_out_last  <= w_last;
      case (r_state)
        R_IDLE: begin
          if (i_start) begin
            r_state <= R_READ;
            r_rcol  <= '0;
            r_bank  <= i_rd_bank;
          end
        end
        R_READ: begin
          // Column wraps back to 0 on the last word, leaving the next pass ready.
          r_rcol <= r_rcol + 1'b1;
          if (w_last) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == R_READ);
  assign o_done      = w_last;
  assign o_rd_ena    = (r_state == R_READ);
  assign o_rd_addr   = {r_bank, r_rcol};
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;

endmodule

// File: rtl/hub75_linebuffer.sv
// Dual-port line buffer with per-word write mask; read data registered (1 cycle after rd_ena).
// No flow control: every enabled access completes in its cycle.
module hub75_linebuffer #(
  parameter int N_WORDS    = 1,
  parameter int WORD_WIDTH = 48,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic [ADDR_WIDTH-1:0]         i_wr_addr,
  input  logic [N_WORDS*WORD_WIDTH-1:0] i_wr_data,
  input  logic [N_WORDS-1:0]            i_wr_mask,
  input  logic                          i_wr_ena,
  input  logic [ADDR_WIDTH-1:0]         i_rd_addr,
  input  logic                          i_rd_ena,
  output logic [N_WORDS*WORD_WIDTH-1:0] o_rd_data
);

  logic [N_WORDS*WORD_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_wr_ena) begin
      for (int w = 0; w < N_WORDS; w++) begin
        if (i_wr_mask[w]) r_mem[i_wr_addr][w*WORD_WIDTH +: WORD_WIDTH] <= i_wr_data[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    if (i_rd_ena) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/hub75_linebuf_sched.sv
// Ping-pong bank scheduler: fills the free bank from the framebuffer, replays the full bank on demand.
// Fill stalls while both banks are full; start-to-first-word is 2 cycles; release during a pass is deferred.
module hub75_linebuf_sched
  import hub75_pkg::*;
#(
  parameter int LOG_N_COLS = LOG_N_COLS_DFLT,
  parameter int LOG_N_ROWS = 5,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hub75_linebuf_sched_if.master bus
);

  localparam logic [LOG_N_COLS-1:0] LAST_COL = '1;

  fill_state_t           r_fstate;
  logic [LOG_N_COLS-1:0] r_wcol;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_fill_req;
  logic                  r_rel_pend;
  logic [LOG_N_ROWS-1:0] r_fill_row;
  logic [LOG_N_ROWS-1:0] r_row_bank [2];
  logic [1:0]            r_full_cnt;

  logic                  w_rd_busy;
  logic                  w_rd_done;
  logic                  w_rd_start;
  logic                  w_drain_rdy;
  logic                  w_wr;
  logic                  w_fill_done;
  logic                  w_rel;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_wr        = (r_fstate == F_DATA) && bus.fill_valid;
  assign w_fill_done = w_wr && (r_wcol == LAST_COL);
  assign w_drain_rdy = (r_full_cnt != 2'd0) && !w_rd_busy;
  assign w_rd_start  = bus.drain_start && w_drain_rdy;
  // A release seen mid-pass (or on its final word) frees the bank as the pass ends.
  assign w_rel = (bus.drain_release && !w_rd_busy && (r_full_cnt != 2'd0))
              || (w_rd_done && (r_rel_pend || bus.drain_release));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fstate      <= F_IDLE;
      r_wcol        <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_fill_req    <= 1'b0;
      r_rel_pend    <= 1'b0;
      r_fill_row    <= '0;
      r_row_bank[0] <= '0;
      r_row_bank[1] <= '0;
      r_full_cnt    <= 2'd0;
    end else begin
      case (r_fstate)
        F_IDLE: begin
          if (r_full_cnt < 2'd2) begin
            r_fstate   <= F_REQ;
            r_fill_req <= 1'b1;
          end
        end
        F_REQ: begin
          if (bus.fill_ack) begin
            r_fstate   <= F_DATA;
            r_fill_req <= 1'b0;
          end
        end
        F_DATA: begin
          if (bus.fill_valid) begin
            r_wcol <= r_wcol + 1'b1;
            if (r_wcol == LAST_COL) begin
              r_fstate              <= F_IDLE;
              r_wr_bank             <= ~r_wr_bank;
              r_fill_row            <= r_fill_row + 1'b1;
              r_row_bank[r_wr_bank] <= r_fill_row;
            end
          end
        end
        default: r_fstate <= F_IDLE;
      endcase

      if (w_rel) r_rd_bank <= ~r_rd_bank;
      r_rel_pend <= w_rd_busy && !w_rd_done && (r_rel_pend || bus.drain_release);

      case ({w_fill_done, w_rel})
        2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
        2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
        default: r_full_cnt <= r_full_cnt;
      endcase
    end
  end

  hub75_linebuf_rdseq #(
    .LOG_N_COLS (LOG_N_COLS)
  ) u_rdseq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_rd_start),
    .i_rd_bank   (r_rd_bank),
    .o_busy      (w_rd_busy),
    .o_done      (w_rd_done),
    .o_rd_ena    (bus.lb_rd_ena),
    .o_rd_addr   (bus.lb_rd_addr),
    .o_out_valid (bus.out_valid),
    .o_out_last  (bus.out_last)
  );

  assign w_rd_data      = bus.lb_rd_data;
  assign bus.out_data   = w_rd_data;
  assign bus.fill_req   = r_fill_req;
  assign bus.fill_row   = r_fill_row;
  assign bus.drain_rdy  = w_drain_rdy;
  assign bus.drain_row  = r_row_bank[r_rd_bank];
  assign bus.lb_wr_ena  = w_wr;
  assign bus.lb_wr_addr = {r_wr_bank, r_wcol};
  assign bus.lb_wr_data = bus.fill_data;
  assign bus.lb_wr_mask = 1'b1;

endmodule

// File: doc/hub75_linebuf_sched.md
Name: hub75_linebuf_sched

Overview:
Ping-pong scheduler for one hub75_linebuffer instance split into two banks (address MSB = bank).
- Fill side: requests rows from the framebuffer readout and writes the streamed pixels into the free bank.
- Drain side: replays a full bank to the shifter once per bit-plane pass, then frees it on release.
- Sits between the framebuffer readout and the BCM/shift logic.

Parameters:
LOG_N_COLS, 6, log2 of columns per line; line length N_COLS = 2^LOG_N_COLS
LOG_N_ROWS, 5, log2 of row count; row counter width
DATA_WIDTH, 48, pixel word width (N_WORDS*WORD_WIDTH of the buffer)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fill_req  out  1  request producer to send row fill_row
fill_row  out  LOG_N_ROWS  row to fetch
fill_ack  in  1  producer accepts request
fill_data  in  DATA_WIDTH  pixel word
fill_valid  in  1  fill_data valid
drain_rdy  out  1  a full bank is available for drain
drain_row  out  LOG_N_ROWS  row held in drain bank
drain_start  in  1  start one read pass
drain_release  in  1  consumer finished with the line
out_data  out  DATA_WIDTH  pixel word (from lb_rd_data)
out_valid  out  1  out_data valid
out_last  out  1  last word of the pass
lb_wr_addr  out  LOG_N_COLS+1  linebuffer write address {bank,col}
lb_wr_data  out  DATA_WIDTH  equals fill_data
lb_wr_mask  out  1  tied all-ones
lb_wr_ena  out  1  write enable
lb_rd_addr  out  LOG_N_COLS+1  read address {bank,col}
lb_rd_ena  out  1  read enable
lb_rd_data  in  DATA_WIDTH  linebuffer read data

Behaviour:
- Reset (rst_n=0 at posedge): all control outputs 0, all counters 0, wr_bank=0, rd_bank=0, full_cnt=0, both FSMs IDLE. Reset mid-transfer aborts with no completion; bank contents are don't-care.
- Fill FSM states and transitions:
  - F_IDLE -> F_REQ when full_cnt<2.
  - F_REQ: fill_req=1, fill_row stable; fill_ack=1 -> F_DATA.
  - F_DATA: each fill_valid writes lb_wr_ena=1, lb_wr_addr={wr_bank,wcol}, wcol++. The word at wcol=N_COLS-1 goes to F_IDLE, toggles wr_bank, increments fill_row (wraps 2^LOG_N_ROWS-1 -> 0) and increments full_cnt.
  - fill_valid outside F_DATA is ignored.
- Drain:
  - drain_rdy = (full_cnt!=0) and read FSM not in R_READ.
  - drain_row = row of rd_bank, tracked as a registered copy captured at fill completion.
- Read FSM states and transitions:
  - R_IDLE: drain_start with drain_rdy -> R_READ, rcol=0.
  - R_READ: lb_rd_ena=1, lb_rd_addr={rd_bank,rcol}, rcol++. After rcol=N_COLS-1 -> R_IDLE.
  - drain_start while not drain_rdy is ignored.
- Output timing: out_valid = lb_rd_ena delayed 1 cycle; out_last = out_valid on the word for rcol=N_COLS-1. Start-to-first-word latency is 2 cycles.
- Multiple passes per line: drain_start may be repeated any number of times before release.
- drain_release:
  - Accepted only in R_IDLE with full_cnt!=0. Toggles rd_bank and decrements full_cnt.
  - If it arrives during R_READ it is held in a pending flag and applied on R_READ exit.
- Same-cycle fill completion and release: net full_cnt unchanged; both bank pointers toggle.
- full_cnt never exceeds 2 or goes below 0. The fill side never writes the bank being drained, guaranteed by full_cnt<2 gating.
- Simultaneous lb_wr_ena and lb_rd_ena always target different banks.

Decomposition:
- Shared package hub75_pkg holds:
  - fill FSM state encodings (F_IDLE, F_REQ, F_DATA)
  - read FSM state encodings (R_IDLE, R_READ)
  - bank-address concatenation helper constant (BANK_BIT = LOG_N_COLS).
- One natural sub-module: hub75_linebuf_rdseq (read FSM + rcol counter + out_valid/out_last pipeline). The fill FSM stays in the top.
- The bench instantiates hub75_linebuffer (N_WORDS=1, ADDR_WIDTH=LOG_N_COLS+1) alongside.

Test Plan:
1. Reset release, producer acks immediately, streams 64 words 0..63 -> fill_req rises cycle 1; lb_wr_addr 0..63; then second fill_req with fill_row=1, drain_rdy=1, drain_row=0.
2. drain_start after fill of row 0 -> out_valid 2 cycles later for 64 cycles with out_data 0..63; out_last only on word 63; lb_rd_addr 0..63.
3. Three drain_start passes without release -> three identical 64-word bursts; fill of row 1 into bank 1 (addr 64..127) completes; full_cnt=2; fill_req stays 0.
4. drain_release during R_READ -> held until pass ends, then rd_bank=1, drain_row=1, fill_req reasserts for row 2 into bank 0.
5. Fill completion and drain_release in the same cycle -> full_cnt unchanged at 1; wr_bank and rd_bank both toggle; no write to the draining bank.
6. rst_n=0 mid-F_DATA (wcol=30) and mid-R_READ -> next cycle all outputs 0, fill_row=0; restart fills from lb_wr_addr 0.
